addsub_pipe_hs: RTL and testbench

ADDSUB_PIPE_HS -- requirements
Module: addsub_pipe_hs

---
 rtl/addsub_pkg.sv | 29 ++
 rtl/addsub_seg.sv | 41 ++++
 rtl/addsub_pipe_hs.sv | 171 +++++++++++++++++
 tb/tb_addsub_pipe_hs.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared sizing helpers and the per-stage control bundle
// for the segmented add/sub pipeline.
package addsub_pkg;

  typedef struct packed {
    logic valid;
    logic op_sub;
    logic carry;
  } stg_t;

  function automatic int pipe_w(input int sw);
    return sw - (sw % 2);
  endfunction

  function automatic int nseg(input int iw, input int sw);
    int pw;
    pw = pipe_w(sw);
    return (iw + pw - 1) / pw;
  endfunction

  function automatic int last_w(input int iw, input int sw);
    int pw;
    int r;
    pw = pipe_w(sw);
    r  = iw % pw;
    return (r == 0) ? pw : r;
  endfunction

endpackage

// File: rtl/addsub_seg.sv
// One pipeline segment: slice add with carry-in,
// result and carry-out registered under enable.
module addsub_seg
  import addsub_pkg::*;
#(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  stg_t         ctl_i,
  output logic [W-1:0] sum_q,
  output stg_t         ctl_q
);

  logic [W-1:0] bx;
  logic [W-1:0] sum_d;
  logic         co;
  stg_t         ctl_d;

  always_comb begin
    bx          = ctl_i.op_sub ? ~b : b;
    {co, sum_d} = {1'b0, a} + {1'b0, bx}
                + {{W{1'b0}}, ctl_i.carry};
    ctl_d       = ctl_i;
    ctl_d.carry = co;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sum_q <= '0;
      ctl_q <= '0;
    end else if (en) begin
      sum_q <= sum_d;
      ctl_q <= ctl_d;
    end
  end

endmodule

// File: rtl/addsub_pipe_hs.sv
// Segmented add/sub pipeline with valid/ready handshake.
// Define ADDSUB_PIPE_OVF_EN to add the signed-overflow output ovf.
module addsub_pipe_hs
  import addsub_pkg::*;
#(
  parameter int IN_WIDTH    = 501,
  parameter int STAGE_WIDTH = 19
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op_sub,
  input  logic [IN_WIDTH-1:0] A,
  input  logic [IN_WIDTH-1:0] B,
  input  logic                Cin,
  output logic [IN_WIDTH-1:0] S,
  output logic                Cout,
`ifdef ADDSUB_PIPE_OVF_EN
  output logic                ovf,
`endif
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int PW   = pipe_w(STAGE_WIDTH);
  localparam int NSEG = nseg(IN_WIDTH, STAGE_WIDTH);
  localparam int LW   = last_w(IN_WIDTH, STAGE_WIDTH);

  logic en;

  logic [IN_WIDTH-1:0] a0_q, a0_d;
  logic [IN_WIDTH-1:0] b0_q, b0_d;
  stg_t                c0_q, c0_d;

  logic [IN_WIDTH-1:0] a_in  [NSEG];
  logic [IN_WIDTH-1:0] b_in  [NSEG];
  logic [IN_WIDTH-1:0] s_out [NSEG];
  stg_t                c_in  [NSEG];
  stg_t                c_out [NSEG];

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = c_out[NSEG-1].valid;
  assign Cout      = c_out[NSEG-1].carry;
  assign S         = s_out[NSEG-1];

  // Subtract is A + ~B + ~Cin, so the borrow is inverted once here.
  always_comb begin
    a0_d        = A;
    b0_d        = B;
    c0_d.valid  = in_valid;
    c0_d.op_sub = op_sub;
    c0_d.carry  = op_sub ? ~Cin : Cin;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a0_q <= '0;
      b0_q <= '0;
      c0_q <= '0;
    end else if (en) begin
      a0_q <= a0_d;
      b0_q <= b0_d;
      c0_q <= c0_d;
    end
  end

  assign a_in[0] = a0_q;
  assign b_in[0] = b0_q;
  assign c_in[0] = c0_q;

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    localparam int LO = k * PW;
    localparam int SW = (k == NSEG - 1) ? LW : PW;
    localparam int HI = LO + SW;

    logic [SW-1:0]       sum_q;
    logic [IN_WIDTH-1:0] s_top;

    addsub_seg #(
      .W(SW)
    ) u_seg (
      .clk   (clk),
      .resetn(resetn),
      .en    (en),
      .a     (a_in[k][LO +: SW]),
      .b     (b_in[k][LO +: SW]),
      .ctl_i (c_in[k]),
      .sum_q (sum_q),
      .ctl_q (c_out[k])
    );

    always_comb begin
      s_top            = '0;
      s_top[LO +: SW]  = sum_q;
    end

    // Operand slices not yet consumed ride along with the beat.
    if (k < NSEG - 1) begin : g_fwd
      logic [IN_WIDTH-HI-1:0] ah_q, ah_d;
      logic [IN_WIDTH-HI-1:0] bh_q, bh_d;

      always_comb begin
        ah_d = a_in[k][IN_WIDTH-1:HI];
        bh_d = b_in[k][IN_WIDTH-1:HI];
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          ah_q <= '0;
          bh_q <= '0;
        end else if (en) begin
          ah_q <= ah_d;
          bh_q <= bh_d;
        end
      end

      assign a_in[k+1] = {ah_q, {HI{1'b0}}};
      assign b_in[k+1] = {bh_q, {HI{1'b0}}};
      assign c_in[k+1] = c_out[k];
    end

    // Finished lower result slices wait for the upper ones.
    if (k > 0) begin : g_lo
      logic [LO-1:0] lo_q, lo_d;

      always_comb begin
        lo_d = s_out[k-1][LO-1:0];
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          lo_q <= '0;
        end else if (en) begin
          lo_q <= lo_d;
        end
      end

      assign s_out[k] = s_top
                      | {{(IN_WIDTH-LO){1'b0}}, lo_q};
    end else begin : g_lo0
      assign s_out[k] = s_top;
    end
  end

`ifdef ADDSUB_PIPE_OVF_EN
  // Operand sign bits travel with the last segment;
  // overflow = same operand signs, different result sign.
  logic [1:0] sg_q, sg_d;

  always_comb begin
    sg_d[1] = a_in[NSEG-1][IN_WIDTH-1];
    sg_d[0] = c_in[NSEG-1].op_sub
            ? ~b_in[NSEG-1][IN_WIDTH-1]
            :  b_in[NSEG-1][IN_WIDTH-1];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sg_q <= '0;
    end else if (en) begin
      sg_q <= sg_d;
    end
  end

  assign ovf = (sg_q[1] == sg_q[0])
            && (S[IN_WIDTH-1] != sg_q[1]);
`endif

endmodule

// File: tb/tb_addsub_pipe_hs.sv
// Directed and streamed checks for addsub_pipe_hs
// (ADDSUB_PIPE_OVF_EN adds the ovf vectors).
module tb_addsub_pipe_hs;

  localparam int W    = 501;
  localparam int WW   = W + 1;
  localparam int LAT  = 28;
  localparam int NSTR = 60;

  logic         clk;
  logic         resetn;
  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic [W-1:0] S;
  logic         Cout;
  logic         out_valid;
  logic         out_ready;
`ifdef ADDSUB_PIPE_OVF_EN
  logic         ovf;
`endif

  int n_chk;
  int n_bad;

  logic [W:0] exp_q [$];
  logic [W:0] got_q [$];
  logic       mon_en;
  logic       stall_prev;
  logic [W:0] held;
  logic       done;

  addsub_pipe_hs #(
    .IN_WIDTH   (W),
    .STAGE_WIDTH(19)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sub   (op_sub),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .S        (S),
    .Cout     (Cout),
`ifdef ADDSUB_PIPE_OVF_EN
    .ovf      (ovf),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [W:0] got,
                     input logic [W:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic op,
                                       input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       input logic cin);
    if (op)
      return {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cin};
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] r;
    r = '0;
    for (int j = 0; j < 16; j++)
      r = (r << 32) | W'($urandom());
    return r;
  endfunction

  // Output monitor: records consumed results, checks hold under stall.
  initial begin
    stall_prev = 1'b0;
    held       = '0;
    forever begin
      @(negedge clk);
      if (resetn && stall_prev)
        chk("stall_hold", {Cout, S}, held);
      stall_prev = resetn && out_valid && !out_ready;
      held       = {Cout, S};
      if (mon_en && resetn && out_valid && out_ready)
        got_q.push_back({Cout, S});
    end
  end

  task automatic push_beat(input logic op,
                           input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic cin);
    int to;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op_sub   = op;
    A        = a;
    B        = b;
    Cin      = cin;
    to       = 0;
    @(negedge clk);
    while (!in_ready && to < 500) begin
      @(negedge clk);
      to++;
    end
    if (!in_ready)
      chk("accept_to", WW'(in_ready), WW'(1));
    exp_q.push_back(model(op, a, b, cin));
  endtask

  task automatic send1(input string tag,
                       input logic op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic cin,
                       input logic [W:0] exp);
    int lat;
    push_beat(op, a, b, cin);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk(tag, {Cout, S}, exp);
    chk({tag, "_lat"}, WW'(lat), WW'(LAT));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] v;
    int           to;
    int           n;

    n_chk     = 0;
    n_bad     = 0;
    mon_en    = 1'b0;
    done      = 1'b0;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    out_ready = 1'b1;
    ones      = '1;

    #2;
    chk("rst_valid0", WW'(out_valid), WW'(0));
    chk("rst_s0", {Cout, S}, '0);
    chk("rst_ready0", WW'(in_ready), WW'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    send1("add_ones", 1'b0, ones, '0, 1'b1, {1'b1, {W{1'b0}}});
    send1("sub_5_7", 1'b1, W'(5), W'(7), 1'b0,
          {1'b0, {(W-1){1'b1}}, 1'b0});
    send1("sub_eq", 1'b1, W'(16'h1234), W'(16'h1234), 1'b0,
          {1'b1, {W{1'b0}}});
    send1("sub_cin", 1'b1, W'(10), W'(3), 1'b1, WW'(1) << W | WW'(6));
    send1("sub_neg1", 1'b1, W'(3), W'(3), 1'b1, {1'b0, {W{1'b1}}});
    send1("add_seg", 1'b0, W'(18'h3ffff), W'(1), 1'b0,
          WW'(32'h0004_0000));

    // Streamed mixed add/sub beats under random backpressure.
    exp_q.delete();
    got_q.delete();
    mon_en = 1'b1;
    fork
      begin
        for (int i = 0; i < NSTR; i++) begin
          v = (i % 10 == 0) ? ones : rnd_w();
          push_beat(i[0], v, rnd_w(), 1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        to = 0;
        while (got_q.size() < NSTR && to < 3000) begin
          @(posedge clk);
          to++;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    mon_en    = 1'b0;
    chk("stream_cnt", WW'(got_q.size()), WW'(NSTR));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk("stream_res", got_q[i], exp_q[i]);

    // Reset with ten beats in flight, head of line stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++)
      push_beat(i[0], W'(i + 1), W'(i + 2), 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    chk("pre_rst_valid", WW'(out_valid), WW'(1));
    resetn = 1'b0;
    #1;
    chk("rst_valid", WW'(out_valid), WW'(0));
    chk("rst_s", {Cout, S}, '0);
    chk("rst_ready", WW'(in_ready), WW'(1));
    got_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (60) @(posedge clk);
    @(negedge clk);
    chk("no_stale", WW'(got_q.size()), WW'(0));
    mon_en = 1'b0;
    send1("post_rst", 1'b0, W'(100), W'(200), 1'b1, WW'(301));

`ifdef ADDSUB_PIPE_OVF_EN
    send1("ovf_add", 1'b0, {1'b0, {(W-1){1'b1}}}, W'(1), 1'b0,
          {2'b01, {(W-1){1'b0}}});
    chk("ovf_add_flag", WW'(ovf), WW'(1));
    send1("ovf_sub", 1'b1, W'(0), W'(1), 1'b0, {1'b0, {W{1'b1}}});
    chk("ovf_sub_flag", WW'(ovf), WW'(0));
`endif

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
